// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches one word per request/ready handshake,
// holds it for the decoder and computes the next PC from jump/branch controls.
// The decoder immediate is carried on const_imm because `const` is a reserved word.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] InstrReg,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        stall,
   input  logic        Branch,
   input  logic        zero,
   input  logic [15:0] const_imm,
   input  logic        Jump,
   input  logic [25:0] address,
   output logic        fetch_err,
   output logic [31:0] retired
);

   localparam logic [31:0] PC_INIT  = {RESET_PC[31:2], 2'b00};
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_FETCH,
      ST_WAIT,
      ST_HOLD,
      ST_ERR
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic        req_q, req_d;
   logic        err_q, err_d;
   logic [31:0] retired_q, retired_d;
   logic [15:0] tmo_cnt_q, tmo_cnt_d;

   logic [31:0] pc_inc;
   logic [31:0] br_off;
   logic [31:0] next_pc;
   logic        advance;

   assign pc_inc  = pc_q + 32'd4;
   assign br_off  = {{14{const_imm[15]}}, const_imm, 2'b00};
   assign advance = (state_q == ST_HOLD) && valid_q && !stall;

   // Jump outranks a taken branch; both only matter on the advance edge.
   always_comb begin
      next_pc = pc_inc;
      if (Jump) begin
         next_pc = {pc_inc[31:28], address, 2'b00};
      end else if (Branch && zero) begin
         next_pc = pc_inc + br_off;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      valid_d   = valid_q;
      req_d     = req_q;
      err_d     = err_q;
      retired_d = retired_q;
      tmo_cnt_d = tmo_cnt_q;

      case (state_q)
         ST_FETCH: begin
            req_d     = 1'b1;
            tmo_cnt_d = '0;
            state_d   = ST_WAIT;
         end
         ST_WAIT: begin
            // A ready arriving on the last allowed cycle still wins over the timeout.
            if (imem_ready) begin
               instr_d = imem_rdata;
               valid_d = 1'b1;
               req_d   = 1'b0;
               state_d = ST_HOLD;
            end else if (tmo_cnt_q == TMO_LAST) begin
               err_d   = 1'b1;
               req_d   = 1'b0;
               state_d = ST_ERR;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end
         ST_HOLD: begin
            if (advance) begin
               pc_d      = next_pc;
               valid_d   = 1'b0;
               retired_d = retired_q + 32'd1;
               state_d   = ST_FETCH;
            end
         end
         ST_ERR: begin
            req_d   = 1'b0;
            valid_d = 1'b0;
            err_d   = 1'b1;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_FETCH;
         pc_q      <= PC_INIT;
         instr_q   <= '0;
         valid_q   <= 1'b0;
         req_q     <= 1'b0;
         err_q     <= 1'b0;
         retired_q <= '0;
         tmo_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         valid_q   <= valid_d;
         req_q     <= req_d;
         err_q     <= err_d;
         retired_q <= retired_d;
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign InstrReg    = instr_q;
   assign instr_valid = valid_q;
   assign pc          = pc_q;
   assign pc_plus4    = pc_inc;
   assign fetch_err   = err_q;
   assign retired     = retired_q;

endmodule
